// File: rtl/core_pkg.sv
// Shared types and constants for the core: LSU state encoding, RV32I load/store
// funct3 codes and writeback result-source selects.
package core_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DRAIN  = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // True when funct3 names an access size that exists for this direction.
    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/core_lsu_strobe.sv
// Combinational byte-lane decode: funct3 and low address bits to byte enables,
// lane-replicated store data and an alignment/legality fault flag.
module core_lsu_strobe
    import core_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    logic [31:0] lane_data;

    always_comb begin
        sel_o      = 4'b0000;
        lane_data  = 32'h0;
        misalign_o = !lsu_f3_legal(we_i, funct3_i);
        // funct3[1:0] encodes the access size for both signed and unsigned loads.
        case (funct3_i[1:0])
            2'b00: begin
                sel_o     = 4'b0001 << addr_lo_i;
                lane_data = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                sel_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_i[15:0]}};
                if (addr_lo_i[0]) begin
                    misalign_o = 1'b1;
                end
            end
            2'b10: begin
                sel_o     = 4'b1111;
                lane_data = wdata_i;
                if (addr_lo_i != 2'b00) begin
                    misalign_o = 1'b1;
                end
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
        wdata_o = we_i ? lane_data : 32'h0;
    end

endmodule

// File: rtl/core_lsu_ctrl.sv
// Memory-stage load/store sequencer over a registered req/ack bus.
// Optional bus-timeout abort is enabled by defining CORE_LSU_TIMEOUT_EN.
module core_lsu_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    lsu_state_t  state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [29:0] bus_addr_q;
    logic [3:0]  bus_sel_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;

    logic [3:0]  strb_sel;
    logic [31:0] strb_wdata;
    logic        strb_misalign;
    logic        start;
    logic        accept;

    core_lsu_strobe u_strobe (
        .we_i       (i_we),
        .funct3_i   (i_funct3),
        .addr_lo_i  (i_addr[1:0]),
        .wdata_i    (i_wdata),
        .sel_o      (strb_sel),
        .wdata_o    (strb_wdata),
        .misalign_o (strb_misalign)
    );

    assign start  = (state_q == LSU_IDLE) && i_req && !i_flush;
    assign accept = start && !strb_misalign;

    // Gated by reset so every output reads 0 while reset is held, even with i_req high.
    assign o_busy     = i_reset_n && (accept || (state_q == LSU_ACCESS) || (state_q == LSU_DRAIN));
    assign o_misalign = i_reset_n && start && strb_misalign;

    assign o_done      = done_q;
    assign o_rdata     = rdata_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_sel   = bus_sel_q;
    assign o_bus_wdata = bus_wdata_q;

`ifdef CORE_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    logic             expire;

    assign expire    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_bus_err = bus_err_q;
`else
    assign o_bus_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= LSU_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 30'h0;
            bus_sel_q   <= 4'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
`ifdef CORE_LSU_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    done_q <= 1'b0;
`ifdef CORE_LSU_TIMEOUT_EN
                    bus_err_q <= 1'b0;
                    cnt_q     <= '0;
`endif
                    if (accept) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= i_we;
                        bus_addr_q  <= i_addr[31:2];
                        bus_sel_q   <= strb_sel;
                        bus_wdata_q <= strb_wdata;
                        state_q     <= LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    if (i_bus_ack) begin
                        bus_req_q <= 1'b0;
                        if (i_flush) begin
                            state_q <= LSU_IDLE;
                        end else begin
                            rdata_q <= bus_we_q ? 32'h0 : i_bus_rdata;
                            done_q  <= 1'b1;
                            state_q <= LSU_RESP;
                        end
                    end else if (i_flush) begin
                        // The bus cycle is already out; wait it off without reporting it.
                        state_q <= LSU_DRAIN;
`ifdef CORE_LSU_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (expire) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= 32'h0;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                        state_q   <= LSU_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                LSU_DRAIN: begin
                    if (i_bus_ack) begin
                        bus_req_q <= 1'b0;
                        state_q   <= LSU_IDLE;
`ifdef CORE_LSU_TIMEOUT_EN
                    end else if (expire) begin
                        bus_req_q <= 1'b0;
                        state_q   <= LSU_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    done_q <= 1'b0;
`ifdef CORE_LSU_TIMEOUT_EN
                    bus_err_q <= 1'b0;
`endif
                    state_q <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Directed bench for core_lsu_ctrl; timeout vectors run only when
// CORE_LSU_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_core_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        ack;
    logic [31:0] brdata;

    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_lsu_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req       (req),
        .i_we        (we),
        .i_funct3    (f3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_flush     (flush),
        .o_busy      (busy),
        .o_done      (done),
        .o_rdata     (rdata),
        .o_misalign  (misalign),
        .o_bus_err   (bus_err),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_sel   (bus_sel),
        .o_bus_wdata (bus_wdata),
        .i_bus_ack   (ack),
        .i_bus_rdata (brdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        f3    = f;
        addr  = a;
        wdata = d;
        #1;
    endtask

    // Issue, hold off ack for 'waits' ACCESS cycles, ack, and stop in the RESP cycle.
    task automatic run_access(input string tag, input logic w, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_waddr, input logic [3:0] exp_sel,
                              input logic [31:0] exp_wdata, input int waits,
                              input logic [31:0] rd, input logic [31:0] exp_rdata);
        issue(w, f, a, d);
        check_val({tag, " busy@issue"}, {31'h0, busy}, 32'h1);
        check_val({tag, " misalign@issue"}, {31'h0, misalign}, 32'h0);
        step();
        req = 1'b0;
        check_val({tag, " bus_req"}, {31'h0, bus_req}, 32'h1);
        check_val({tag, " bus_we"}, {31'h0, bus_we}, {31'h0, w});
        check_val({tag, " bus_addr"}, {2'b00, bus_addr}, exp_waddr);
        check_val({tag, " bus_sel"}, {28'h0, bus_sel}, {28'h0, exp_sel});
        check_val({tag, " bus_wdata"}, bus_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            check_val({tag, " busy@wait"}, {31'h0, busy}, 32'h1);
            step();
        end
        ack    = 1'b1;
        brdata = rd;
        #1;
        check_val({tag, " done@ack"}, {31'h0, done}, 32'h0);
        step();
        ack    = 1'b0;
        brdata = 32'h0;
        check_val({tag, " done"}, {31'h0, done}, 32'h1);
        check_val({tag, " rdata"}, rdata, exp_rdata);
        check_val({tag, " busy@done"}, {31'h0, busy}, 32'h0);
        check_val({tag, " bus_req@done"}, {31'h0, bus_req}, 32'h0);
        check_val({tag, " bus_err"}, {31'h0, bus_err}, 32'h0);
    endtask

    task automatic check_misalign(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a);
        issue(w, f, a, 32'h0);
        check_val({tag, " misalign"}, {31'h0, misalign}, 32'h1);
        check_val({tag, " busy"}, {31'h0, busy}, 32'h0);
        step();
        req = 1'b0;
        check_val({tag, " bus_req"}, {31'h0, bus_req}, 32'h0);
        check_val({tag, " done"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        flush = 1'b0; ack = 1'b0; brdata = 32'h0;
        #12;
        check_val("rst bus_req", {31'h0, bus_req}, 32'h0);
        check_val("rst busy", {31'h0, busy}, 32'h0);
        check_val("rst done", {31'h0, done}, 32'h0);
        check_val("rst rdata", rdata, 32'h0);
        check_val("rst bus_sel", {28'h0, bus_sel}, 32'h0);
        #10;
        reset_n = 1'b1;
        step();

        run_access("LW 0x100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h40, 4'b1111, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF);
        step();
        check_val("LW 0x100 done clears", {31'h0, done}, 32'h0);

        run_access("SB 0x203", 1'b1, 3'b000, 32'h203, 32'h000000AB, 32'h80, 4'b1000, 32'hABABABAB, 1, 32'h55555555, 32'h0);
        step();
        run_access("SH 0x202", 1'b1, 3'b001, 32'h202, 32'h12345678, 32'h80, 4'b1100, 32'h56785678, 0, 32'h0, 32'h0);
        step();
        run_access("SW 0x10C", 1'b1, 3'b010, 32'h10C, 32'h01234567, 32'h43, 4'b1111, 32'h01234567, 1, 32'h0, 32'h0);
        step();
        run_access("LB 0x101", 1'b0, 3'b000, 32'h101, 32'hFFFFFFFF, 32'h40, 4'b0010, 32'h0, 0, 32'h0000AB00, 32'h0000AB00);
        step();
        run_access("LHU 0x106", 1'b0, 3'b101, 32'h106, 32'h0, 32'h41, 4'b1100, 32'h0, 0, 32'h8001_0000, 32'h8001_0000);
        step();

        check_misalign("LH 0x101", 1'b0, 3'b001, 32'h101);
        check_misalign("LW 0x102", 1'b0, 3'b010, 32'h102);
        check_misalign("LD f3=011", 1'b0, 3'b011, 32'h100);
        check_misalign("LWU f3=110", 1'b0, 3'b110, 32'h100);
        check_misalign("ST f3=100", 1'b1, 3'b100, 32'h100);
        check_misalign("SW 0x201", 1'b1, 3'b010, 32'h201);

        // Request with flush in IDLE is dropped.
        flush = 1'b1;
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        check_val("idle flush busy", {31'h0, busy}, 32'h0);
        check_val("idle flush misalign", {31'h0, misalign}, 32'h0);
        step();
        req = 1'b0; flush = 1'b0;
        check_val("idle flush bus_req", {31'h0, bus_req}, 32'h0);

        // Flush while ACCESS: drain until ack, no done, rdata keeps 0x80010000.
        issue(1'b0, 3'b010, 32'h300, 32'h0);
        step();
        req = 1'b0;
        flush = 1'b1;
        #1;
        check_val("flush busy@access", {31'h0, busy}, 32'h1);
        step();
        flush = 1'b0;
        check_val("drain busy", {31'h0, busy}, 32'h1);
        check_val("drain bus_req", {31'h0, bus_req}, 32'h1);
        check_val("drain done", {31'h0, done}, 32'h0);
        step();
        check_val("drain busy2", {31'h0, busy}, 32'h1);
        ack = 1'b1; brdata = 32'h99999999;
        #1;
        check_val("drain busy@ack", {31'h0, busy}, 32'h1);
        step();
        ack = 1'b0; brdata = 32'h0;
        check_val("drain done@end", {31'h0, done}, 32'h0);
        check_val("drain busy@end", {31'h0, busy}, 32'h0);
        check_val("drain bus_req@end", {31'h0, bus_req}, 32'h0);
        check_val("drain rdata kept", rdata, 32'h80010000);
        run_access("LW after drain", 1'b0, 3'b010, 32'h300, 32'h0, 32'hC0, 4'b1111, 32'h0, 1, 32'h13579BDF, 32'h13579BDF);
        step();

        // Flush and ack in the same ACCESS cycle: straight back to IDLE, no done.
        issue(1'b0, 3'b010, 32'h304, 32'h0);
        step();
        req = 1'b0; flush = 1'b1; ack = 1'b1; brdata = 32'h77777777;
        step();
        flush = 1'b0; ack = 1'b0; brdata = 32'h0;
        check_val("flush+ack done", {31'h0, done}, 32'h0);
        check_val("flush+ack bus_req", {31'h0, bus_req}, 32'h0);
        check_val("flush+ack busy", {31'h0, busy}, 32'h0);
        check_val("flush+ack rdata", rdata, 32'h13579BDF);

        // Back-to-back: request during RESP ignored, accepted in following IDLE.
        run_access("B2B first", 1'b0, 3'b010, 32'h400, 32'h0, 32'h100, 4'b1111, 32'h0, 0, 32'h0BADCAFE, 32'h0BADCAFE);
        issue(1'b0, 3'b010, 32'h404, 32'h0);
        check_val("B2B busy@resp", {31'h0, busy}, 32'h0);
        step();
        check_val("B2B bus_req@idle", {31'h0, bus_req}, 32'h0);
        check_val("B2B busy@idle", {31'h0, busy}, 32'h1);
        step();
        req = 1'b0;
        check_val("B2B bus_req", {31'h0, bus_req}, 32'h1);
        check_val("B2B bus_addr", {2'b00, bus_addr}, 32'h101);
        ack = 1'b1; brdata = 32'h2468ACE0;
        step();
        ack = 1'b0; brdata = 32'h0;
        check_val("B2B done", {31'h0, done}, 32'h1);
        check_val("B2B rdata", rdata, 32'h2468ACE0);
        step();

        // Asynchronous reset mid-access, with i_req still asserted.
        issue(1'b1, 3'b010, 32'h500, 32'hCAFEF00D);
        step();
        check_val("rst-mid bus_req before", {31'h0, bus_req}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_val("rst-mid bus_req", {31'h0, bus_req}, 32'h0);
        check_val("rst-mid busy", {31'h0, busy}, 32'h0);
        check_val("rst-mid bus_we", {31'h0, bus_we}, 32'h0);
        check_val("rst-mid bus_wdata", bus_wdata, 32'h0);
        check_val("rst-mid bus_addr", {2'b00, bus_addr}, 32'h0);
        check_val("rst-mid rdata", rdata, 32'h0);
        #2;
        req = 1'b0;
        reset_n = 1'b1;
        step();
        run_access("LW after rst", 1'b0, 3'b010, 32'h104, 32'h0, 32'h41, 4'b1111, 32'h0, 0, 32'hFEEDFACE, 32'hFEEDFACE);
        step();

`ifdef CORE_LSU_TIMEOUT_EN
        // No ack: four ACCESS cycles, then done with bus_err and zero data.
        issue(1'b0, 3'b010, 32'h600, 32'h0);
        step();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("TO busy", {31'h0, busy}, 32'h1);
            check_val("TO done early", {31'h0, done}, 32'h0);
            step();
        end
        check_val("TO done", {31'h0, done}, 32'h1);
        check_val("TO bus_err", {31'h0, bus_err}, 32'h1);
        check_val("TO rdata", rdata, 32'h0);
        check_val("TO bus_req", {31'h0, bus_req}, 32'h0);
        step();
        check_val("TO err clears", {31'h0, bus_err}, 32'h0);
        // Ack in the expiry cycle completes normally.
        run_access("TO ack@4", 1'b0, 3'b010, 32'h604, 32'h0, 32'h181, 4'b1111, 32'h0, 3, 32'h31415926, 32'h31415926);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
